// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding and width helpers for the pipelined signed ALU.
package alu_pipe_pkg;

    localparam int unsigned NUM_OPS = 8;
    localparam int unsigned SEL_W   = $clog2(NUM_OPS);

    typedef enum logic [SEL_W-1:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLA,
        OP_SRA,
        OP_MUL
    } op_e;

    // Bits of B used as shift amount; kept >= 1 so slices stay legal.
    function automatic int unsigned shamt_w(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational signed ALU datapath with overflow detection and flags.
// Clamping on overflow is built in when ALU_PIPE_SAT_EN is defined.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic [W-1:0]     C,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam int unsigned SW = shamt_w(W);
    localparam int unsigned PW = 2 * W;

    logic [W:0]    sum;
    logic [W:0]    dif;
    logic [PW-1:0] prod;
    logic [PW-1:0] sla_full;
    logic [SW-1:0] sh;
    logic [W-1:0]  res;
    logic          ovf;

    assign sh       = B[SW-1:0];
    assign sum      = {A[W-1], A} + {B[W-1], B};
    assign dif      = {A[W-1], A} - {B[W-1], B};
    // Low 2W bits of the product of sign-extended operands are the exact signed product.
    assign prod     = {{W{A[W-1]}}, A} * {{W{B[W-1]}}, B};
    assign sla_full = {{W{A[W-1]}}, A} << sh;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (sel)
            OP_ADD: begin
                res = sum[W-1:0];
                ovf = sum[W] ^ sum[W-1];
            end
            OP_SUB: begin
                res = dif[W-1:0];
                ovf = dif[W] ^ dif[W-1];
            end
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_SLA: begin
                res = sla_full[W-1:0];
                ovf = (sla_full[PW-1:W-1] != '0) && (sla_full[PW-1:W-1] != '1);
            end
            OP_SRA: res = W'($signed(A) >>> sh);
            OP_MUL: begin
                res = prod[W-1:0];
                ovf = (prod[PW-1:W-1] != '0) && (prod[PW-1:W-1] != '1);
            end
            default: begin
                res = '0;
                ovf = 1'b0;
            end
        endcase
    end

`ifdef ALU_PIPE_SAT_EN
    logic neg;

    // Sign of the full-precision result selects the clamp rail.
    always_comb begin
        neg = A[W-1];
        case (sel)
            OP_ADD:  neg = sum[W];
            OP_SUB:  neg = dif[W];
            OP_MUL:  neg = prod[PW-1];
            default: neg = A[W-1];
        endcase
    end

    assign C = !ovf ? res : (neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
`else
    assign C = res;
`endif

    assign V = ovf;
    assign Z = (C == '0);
    assign N = C[W-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined signed ALU with overflow event counter.
// Define ALU_PIPE_SAT_EN to clamp overflowing results instead of wrapping.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     C,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [SEL_W-1:0] s1_sel;
    logic             s1_load;
    logic             s2_load;

    logic [W-1:0]     core_c;
    logic             core_z;
    logic             core_n;
    logic             core_v;

    // Each stage advances when it is empty or the stage after it is moving.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= A;
                s1_b   <= B;
                s1_sel <= sel;
            end
        end
    end

    alu_pipe_core #(
        .W (W)
    ) u_core (
        .sel (s1_sel),
        .A   (s1_a),
        .B   (s1_b),
        .C   (core_c),
        .Z   (core_z),
        .N   (core_n),
        .V   (core_v)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            C         <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            V         <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                C <= core_c;
                Z <= core_z;
                N <= core_n;
                V <= core_v;
            end
        end
    end

    // Saturating count of overflowing results actually handed to the sink.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && V && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule
